// File: rtl/itrx_amba2_ahb_arb.sv
// AMBA2 AHB round-robin bus arbiter. It keeps locked sequences and fixed-length
// bursts with one master, and masks masters that a slave has SPLIT until that slave releases them.
module itrx_amba2_ahb_arb #(
    parameter int unsigned NM      = 16,
    parameter int unsigned NS      = 16,
    parameter int unsigned DEF_MST = 0,
    parameter int unsigned HMW     = 4
) (
    input  logic             hclk_i,
    input  logic             hreset_i,
    input  logic [NM-1:0]    hbusreq_i,
    input  logic [NM-1:0]    hlock_i,
    input  logic [1:0]       htrans_i,
    input  logic [2:0]       hburst_i,
    input  logic             hready_i,
    input  logic [1:0]       hresp_i,
    input  logic [NS*NM-1:0] hsplit_i,
    output logic [NM-1:0]    hgrant_o,
    output logic [HMW-1:0]   hmaster_o,
    output logic             hmastlock_o
);

    localparam int unsigned CNT_W = 4;

    localparam logic [1:0] TR_IDLE   = 2'd0;
    localparam logic [1:0] TR_NONSEQ = 2'd2;
    localparam logic [1:0] TR_SEQ    = 2'd3;
    localparam logic [1:0] RSP_OKAY  = 2'd0;
    localparam logic [1:0] RSP_SPLIT = 2'd3;
    localparam logic [2:0] BU_INCR   = 3'd1;

    logic [NM-1:0]    grant_q, grant_d;
    logic [HMW-1:0]   master_q, master_d;
    logic             mastlock_q, mastlock_d;
    logic [HMW-1:0]   master_dp_q, master_dp_d;
    logic [NM-1:0]    split_mask_q, split_mask_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             incr_open_q, incr_open_d;
    logic [HMW-1:0]   rr_last_q, rr_last_d;
    logic             lock_prev_q, lock_prev_d;

    logic             arb_ok, split_evt, lock_now, lock_hold;
    logic [NM-1:0]    eligible, split_set, split_clr;
    logic [HMW-1:0]   grant_idx, pick_idx, next_idx;
    int               best_dist;

    // Number of beats minus one for a fixed-length burst type.
    function automatic logic [CNT_W-1:0] burst_beats(input logic [2:0] burst);
        case (burst)
            3'd2, 3'd3: burst_beats = CNT_W'(3);
            3'd4, 3'd5: burst_beats = CNT_W'(7);
            3'd6, 3'd7: burst_beats = CNT_W'(15);
            default:    burst_beats = CNT_W'(0);
        endcase
    endfunction

    always_comb begin
        beat_cnt_d  = beat_cnt_q;
        incr_open_d = incr_open_q;
        if (hready_i) begin
            case (htrans_i)
                TR_NONSEQ: begin
                    beat_cnt_d  = burst_beats(hburst_i);
                    incr_open_d = (hburst_i == BU_INCR);
                end
                TR_SEQ: begin
                    if (beat_cnt_q != '0) beat_cnt_d = beat_cnt_q - CNT_W'(1);
                end
                default: ;
            endcase
        end

        // The last beat of a burst is itself an arbitration point, so the
        // post-update count is what decides it.
        arb_ok = hready_i && ((htrans_i == TR_IDLE) || (beat_cnt_d == '0) ||
                              incr_open_d || (hresp_i != RSP_OKAY));

        split_evt   = hready_i && (hresp_i == RSP_SPLIT);
        lock_now    = |(grant_q & hlock_i & hbusreq_i);
        lock_hold   = (lock_now || lock_prev_q) && !split_evt;
        lock_prev_d = lock_now && !split_evt;

        grant_idx = '0;
        for (int i = 0; i < int'(NM); i++) begin
            if (grant_q[i]) grant_idx = HMW'(i);
        end

        // Round-robin: smallest distance after rr_last wins.
        eligible  = hbusreq_i & ~split_mask_q;
        pick_idx  = HMW'(DEF_MST);
        best_dist = int'(NM);
        for (int j = 0; j < int'(NM); j++) begin
            if (eligible[j]) begin
                if (((j + int'(NM) - 1 - int'(rr_last_q)) % int'(NM)) < best_dist) begin
                    best_dist = (j + int'(NM) - 1 - int'(rr_last_q)) % int'(NM);
                    pick_idx  = HMW'(j);
                end
            end
        end

        if (lock_hold)   next_idx = grant_idx;
        else if (arb_ok) next_idx = pick_idx;
        else             next_idx = grant_idx;

        for (int i = 0; i < int'(NM); i++) begin
            grant_d[i] = (HMW'(i) == next_idx);
        end

        rr_last_d = rr_last_q;
        if ((next_idx != grant_idx) && |(grant_d & hbusreq_i)) rr_last_d = next_idx;

        master_d    = master_q;
        mastlock_d  = mastlock_q;
        master_dp_d = master_dp_q;
        if (hready_i) begin
            master_d    = grant_idx;
            mastlock_d  = |(grant_q & hlock_i);
            master_dp_d = master_q;
        end

        split_clr = '0;
        for (int s = 0; s < int'(NS); s++) begin
            split_clr = split_clr | hsplit_i[s*int'(NM) +: NM];
        end
        for (int i = 0; i < int'(NM); i++) begin
            split_set[i] = split_evt && (HMW'(i) == master_dp_q);
        end
        // A release arriving with the SPLIT response wins.
        split_mask_d = (split_mask_q | split_set) & ~split_clr;
    end

    always_ff @(posedge hclk_i or posedge hreset_i) begin
        if (hreset_i) begin
            grant_q      <= NM'(1) << DEF_MST;
            master_q     <= HMW'(DEF_MST);
            mastlock_q   <= 1'b0;
            master_dp_q  <= HMW'(DEF_MST);
            split_mask_q <= '0;
            beat_cnt_q   <= '0;
            incr_open_q  <= 1'b0;
            rr_last_q    <= HMW'(DEF_MST);
            lock_prev_q  <= 1'b0;
        end else begin
            grant_q      <= grant_d;
            master_q     <= master_d;
            mastlock_q   <= mastlock_d;
            master_dp_q  <= master_dp_d;
            split_mask_q <= split_mask_d;
            beat_cnt_q   <= beat_cnt_d;
            incr_open_q  <= incr_open_d;
            rr_last_q    <= rr_last_d;
            lock_prev_q  <= lock_prev_d;
        end
    end

    assign hgrant_o    = grant_q;
    assign hmaster_o   = master_q;
    assign hmastlock_o = mastlock_q;

endmodule

// File: tb/tb_itrx_amba2_ahb_arb.sv
// Directed table-driven bench for itrx_amba2_ahb_arb (NM=16, NS=16, DEF_MST=0).
module tb_itrx_amba2_ahb_arb;

    localparam int unsigned NM  = 16;
    localparam int unsigned NS  = 16;
    localparam int unsigned HMW = 4;

    localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, NSQ = 2'd2, SEQ = 2'd3;
    localparam logic [1:0] OKAY = 2'd0, SPLIT = 2'd3;

    logic             clk, rst;
    logic [NM-1:0]    hbusreq, hlock, hgrant;
    logic [1:0]       htrans, hresp;
    logic [2:0]       hburst;
    logic             hready, hmastlock;
    logic [NS*NM-1:0] hsplit;
    logic [HMW-1:0]   hmaster;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [15:0] req;
        logic [15:0] lock;
        logic [1:0]  trans;
        logic [2:0]  burst;
        logic        rdy;
        logic [1:0]  resp;
        int          split_bit;
        logic [15:0] exp_gnt;
        logic [3:0]  exp_mst;
        logic        exp_lock;
    } vec_t;

    vec_t tbl[$];

    itrx_amba2_ahb_arb #(.NM(NM), .NS(NS), .DEF_MST(0), .HMW(HMW)) dut (
        .hclk_i     (clk),
        .hreset_i   (rst),
        .hbusreq_i  (hbusreq),
        .hlock_i    (hlock),
        .htrans_i   (htrans),
        .hburst_i   (hburst),
        .hready_i   (hready),
        .hresp_i    (hresp),
        .hsplit_i   (hsplit),
        .hgrant_o   (hgrant),
        .hmaster_o  (hmaster),
        .hmastlock_o(hmastlock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [15:0] req, input logic [15:0] lock,
                               input logic [1:0] trans, input logic [2:0] burst,
                               input logic rdy, input logic [1:0] resp, input int sb,
                               input logic [15:0] g, input logic [3:0] m, input logic ml);
        vec_t r;
        r.req = req; r.lock = lock; r.trans = trans; r.burst = burst; r.rdy = rdy;
        r.resp = resp; r.split_bit = sb; r.exp_gnt = g; r.exp_mst = m; r.exp_lock = ml;
        return r;
    endfunction

    task automatic drive(input vec_t r);
        hbusreq = r.req;
        hlock   = r.lock;
        htrans  = r.trans;
        hburst  = r.burst;
        hready  = r.rdy;
        hresp   = r.resp;
        hsplit  = '0;
        if (r.split_bit >= 0) hsplit[r.split_bit] = 1'b1;
    endtask

    task automatic check_outs(input string tag, input logic [15:0] g, input logic [3:0] m,
                              input logic ml);
        check({tag, " hgrant"}, 32'(hgrant), 32'(g));
        check({tag, " hmaster"}, 32'(hmaster), 32'(m));
        check({tag, " hmastlock"}, 32'(hmastlock), 32'(ml));
        check({tag, " onehot"}, 32'($onehot(hgrant)), 32'd1);
    endtask

    initial begin
        // Round-robin between masters 1 and 2
        for (int k = 0; k < 2; k++) begin
            tbl.push_back(v(16'h0006, 16'h0, NSQ, 3'd0, 1'b1, OKAY, -1, 16'h0002, 4'(k == 0 ? 0 : 2), 1'b0));
            tbl.push_back(v(16'h0006, 16'h0, NSQ, 3'd0, 1'b1, OKAY, -1, 16'h0004, 4'd1, 1'b0));
        end
        // INCR8 by master 1 with master 3 waiting, one BUSY and one wait state inside
        tbl.push_back(v(16'h0002, 16'h0, IDLE, 3'd0, 1'b1, OKAY, -1, 16'h0002, 4'd2, 1'b0));
        tbl.push_back(v(16'h000A, 16'h0, NSQ,  3'd5, 1'b1, OKAY, -1, 16'h0002, 4'd1, 1'b0));
        tbl.push_back(v(16'h000A, 16'h0, SEQ,  3'd5, 1'b1, OKAY, -1, 16'h0002, 4'd1, 1'b0));
        tbl.push_back(v(16'h000A, 16'h0, SEQ,  3'd5, 1'b1, OKAY, -1, 16'h0002, 4'd1, 1'b0));
        tbl.push_back(v(16'h000A, 16'h0, BUSY, 3'd5, 1'b1, OKAY, -1, 16'h0002, 4'd1, 1'b0));
        tbl.push_back(v(16'h000A, 16'h0, SEQ,  3'd5, 1'b0, OKAY, -1, 16'h0002, 4'd1, 1'b0));
        for (int k = 0; k < 4; k++)
            tbl.push_back(v(16'h000A, 16'h0, SEQ, 3'd5, 1'b1, OKAY, -1, 16'h0002, 4'd1, 1'b0));
        tbl.push_back(v(16'h000A, 16'h0, SEQ,  3'd5, 1'b1, OKAY, -1, 16'h0008, 4'd1, 1'b0));
        tbl.push_back(v(16'h0000, 16'h0, IDLE, 3'd0, 1'b1, OKAY, -1, 16'h0001, 4'd3, 1'b0));
        // Locked sequence by master 2 with master 5 waiting
        tbl.push_back(v(16'h0004, 16'h4, IDLE, 3'd0, 1'b1, OKAY, -1, 16'h0004, 4'd0, 1'b0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(v(16'h0024, 16'h4, NSQ, 3'd0, 1'b1, OKAY, -1, 16'h0004, 4'd2, 1'b1));
        tbl.push_back(v(16'h0024, 16'h0, NSQ,  3'd0, 1'b1, OKAY, -1, 16'h0004, 4'd2, 1'b0));
        tbl.push_back(v(16'h0024, 16'h0, NSQ,  3'd0, 1'b1, OKAY, -1, 16'h0020, 4'd2, 1'b0));
        tbl.push_back(v(16'h0000, 16'h0, IDLE, 3'd0, 1'b1, OKAY, -1, 16'h0001, 4'd5, 1'b0));
        // Slave 4 SPLITs master 1, then releases it
        tbl.push_back(v(16'h0002, 16'h0, IDLE, 3'd0, 1'b1, OKAY,  -1, 16'h0002, 4'd0, 1'b0));
        tbl.push_back(v(16'h0002, 16'h0, NSQ,  3'd0, 1'b1, OKAY,  -1, 16'h0002, 4'd1, 1'b0));
        tbl.push_back(v(16'h0002, 16'h0, IDLE, 3'd0, 1'b1, OKAY,  -1, 16'h0002, 4'd1, 1'b0));
        tbl.push_back(v(16'h0006, 16'h0, IDLE, 3'd0, 1'b1, SPLIT, -1, 16'h0004, 4'd1, 1'b0));
        tbl.push_back(v(16'h0006, 16'h0, IDLE, 3'd0, 1'b1, OKAY,  -1, 16'h0004, 4'd2, 1'b0));
        tbl.push_back(v(16'h0002, 16'h0, IDLE, 3'd0, 1'b1, OKAY,  -1, 16'h0001, 4'd2, 1'b0));
        tbl.push_back(v(16'h0002, 16'h0, IDLE, 3'd0, 1'b1, OKAY,  65, 16'h0001, 4'd0, 1'b0));
        tbl.push_back(v(16'h0002, 16'h0, IDLE, 3'd0, 1'b1, OKAY,  -1, 16'h0002, 4'd0, 1'b0));
        // SPLIT and release for master 1 in the same cycle: mask stays clear
        tbl.push_back(v(16'h0002, 16'h0, IDLE, 3'd0, 1'b1, OKAY,  -1, 16'h0002, 4'd1, 1'b0));
        tbl.push_back(v(16'h0002, 16'h0, IDLE, 3'd0, 1'b1, OKAY,  -1, 16'h0002, 4'd1, 1'b0));
        tbl.push_back(v(16'h0002, 16'h0, IDLE, 3'd0, 1'b1, SPLIT, 65, 16'h0002, 4'd1, 1'b0));
        tbl.push_back(v(16'h0002, 16'h0, IDLE, 3'd0, 1'b1, OKAY,  -1, 16'h0002, 4'd1, 1'b0));
        // Idle bus falls back to the default master
        tbl.push_back(v(16'h0000, 16'h0, IDLE, 3'd0, 1'b1, OKAY,  -1, 16'h0001, 4'd1, 1'b0));
        tbl.push_back(v(16'h0000, 16'h0, IDLE, 3'd0, 1'b1, OKAY,  -1, 16'h0001, 4'd0, 1'b0));
        // Mask master 1 again, then master 3 starts a locked WRAP16
        tbl.push_back(v(16'h0008, 16'h0, IDLE, 3'd0, 1'b1, SPLIT, -1, 16'h0008, 4'd0, 1'b0));
        tbl.push_back(v(16'h0008, 16'h8, NSQ,  3'd6, 1'b1, OKAY,  -1, 16'h0008, 4'd3, 1'b1));
        for (int k = 0; k < 4; k++)
            tbl.push_back(v(16'h0008, 16'h8, SEQ, 3'd6, 1'b1, OKAY, -1, 16'h0008, 4'd3, 1'b1));

        rst = 1'b1;
        drive(v(16'h0, 16'h0, IDLE, 3'd0, 1'b1, OKAY, -1, 16'h0, 4'd0, 1'b0));
        repeat (2) @(posedge clk);
        #1;
        check_outs("reset", 16'h0001, 4'd0, 1'b0);
        rst = 1'b0;

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k]);
            @(posedge clk);
            #1;
            check_outs($sformatf("row%0d", k), tbl[k].exp_gnt, tbl[k].exp_mst, tbl[k].exp_lock);
        end

        // Asynchronous reset in the middle of WRAP16 beat 5 of a locked burst
        #2;
        rst = 1'b1;
        #1;
        check_outs("async_rst", 16'h0001, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        // Master 1 was masked before reset; it must be grantable right away
        drive(v(16'h0002, 16'h0, IDLE, 3'd0, 1'b1, OKAY, -1, 16'h0, 4'd0, 1'b0));
        @(posedge clk);
        #1;
        check_outs("post_rst", 16'h0002, 4'd0, 1'b0);
        @(posedge clk);
        #1;
        check_outs("post_rst2", 16'h0002, 4'd1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/itrx_amba2_ahb_arb.md
# itrx_amba2_ahb_arb

AMBA2 AHB bus arbiter for the shared `itrx_amba2_ahb` multi-master bus. It grants the bus among up to NM masters using round-robin priority. It honours locked transfers, does not break fixed-length bursts, and masks masters that a slave has SPLIT until that slave releases them. It drives `hgrant`, `hmaster` and `hmastlock` for the bus, the decoder and the slaves.

## Interface
- `NM`, 16: number of masters, 2..16.
- `NS`, 16: number of slaves, 1..16.
- `DEF_MST`, 0: default master index; granted when nobody is requesting.
- `HMW`, 4: width of `hmaster`; must satisfy 2^HMW >= NM.

Ports (all synchronous to `hclk`):
- `hclk`  in  1  bus clock.
- `hreset`  in  1  asynchronous, active-high reset.
- `hbusreq`  in  NM  per-master bus request.
- `hlock`  in  NM  per-master lock request.
- `htrans`  in  2  selected transfer type: IDLE=0, BUSY=1, NONSEQ=2, SEQ=3.
- `hburst`  in  3  selected burst type: SINGLE=0, INCR=1, WRAP4/INCR4=2/3, WRAP8/INCR8=4/5, WRAP16/INCR16=6/7.
- `hready`  in  1  bus ready.
- `hresp`  in  2  selected response: OKAY=0, ERROR=1, RETRY=2, SPLIT=3.
- `hsplit`  in  NS*NM  slave s release vector at bits [s*NM +: NM].
- `hgrant`  out  NM  one-hot grant, registered.
- `hmaster`  out  HMW  index of the master owning the address phase, registered.
- `hmastlock`  out  1  current address phase is locked, registered.

## Operation
**Reset values:**
- `hgrant` = one-hot(`DEF_MST`), `hmaster` = `DEF_MST`, `hmastlock` = 0.
- `split_mask` = 0, `beat_cnt` = 0, `rr_last` = `DEF_MST`.

**Eligibility:** master m is eligible when `hbusreq[m]` = 1 and `split_mask[m]` = 0.

**Burst counter (`beat_cnt`, 4 bits)**, updated only when `hready` = 1:
- NONSEQ loads beats-1: SINGLE→0, x4→3, x8→7, x16→15, INCR→0 with flag `incr_open`=1.
- SEQ decrements, saturating at 0.
- BUSY and IDLE hold the count.

**Arbitration point (`arb_ok`)** is true when `hready` = 1 and any of the following holds:
- `htrans` is IDLE.
- `beat_cnt` = 0, or the current NONSEQ loads 0.
- `incr_open` = 1.
- `hresp` != OKAY, which ends the burst.

**Next grant, computed each cycle:**
- Lock: if the granted master holds `hlock` = 1 and `hbusreq` = 1, the grant is held regardless of `arb_ok`. It is also held for one extra cycle after `hlock` drops, so the final locked transfer completes.
- Otherwise, if `arb_ok`: the first eligible master in round-robin order starting at `rr_last`+1 (mod NM). If none is eligible, grant `DEF_MST`.
- If not `arb_ok`: hold the grant.
- `rr_last` becomes the new grantee whenever the grant changes to a requesting master.

**Ownership:**
- When `hready` = 1: `hmaster` <= index(`hgrant`) and `hmastlock` <= `hlock`[index(`hgrant`)].
- When `hready` = 0: both hold.

**Split mask:**
- Set: `split_mask[hmaster_d]` sets when `hresp` = SPLIT and `hready` = 1. `hmaster_d` is `hmaster` delayed one `hready`-qualified cycle, i.e. the data-phase owner.
- Clear: bit m clears when the OR over s of `hsplit[s*NM+m]` = 1.
- Simultaneous set and clear for the same m: clear wins.
- A SPLIT on a locked transfer still sets the mask, and the lock hold is dropped.

**Default master:** `DEF_MST` is granted even if it is masked; it is required to drive IDLE.

RETRY does not mask the master; the master simply re-arbitrates.

## Timing
- Grant latency: `hbusreq` sampled at cycle n → `hgrant` valid at n+1, provided `arb_ok` at n.
- `hmaster` changes on the first cycle with `hready` = 1 after `hgrant` changes; wait states stretch this.
- Fixed burst: the grant is constant from the NONSEQ until the last SEQ beat is accepted. The handover is visible on `hgrant` in the cycle after the last beat.
- `hgrant` is one-hot in every cycle; it is never all zeros.
- Reset asserted mid-burst or mid-lock returns all state to reset values asynchronously. The first grant after deassertion follows the normal rules.

## Test plan
- **Round-robin:** `hbusreq`=0x0006 (masters 1 and 2), SINGLE transfers with `hready`=1 → grants alternate 1,2,1,2. `hmaster` trails `hgrant` by one cycle.
- **Burst protection:** master 1 is in INCR8 when master 3 requests → `hgrant` stays 0x0002 through 8 accepted beats plus 2 inserted BUSY/wait cycles. It moves to 0x0008 only after beat 8.
- **Lock:** master 2 asserts `hlock` for 3 SINGLEs while master 5 requests → `hmastlock`=1 on those address phases. The grant moves to 5 only one cycle after `hlock` drops.
- **Split:** slave 4 returns SPLIT to master 1 → `split_mask`=0x0002 and master 1 is skipped while requesting. `hsplit` bit [4*NM+1] pulses → mask clears and master 1 is granted at the next arbitration point.
- **Idle / default:** `hbusreq`=0 → `hgrant`=one-hot(`DEF_MST`). If `hresp`=SPLIT and `hsplit` arrive in the same cycle for the same master, the mask stays clear.
- **Reset:** assert `hreset` during a WRAP16 beat 5 → outputs immediately show `DEF_MST`, `hmastlock`=0, and all masks cleared.
